// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: grants IF fetches or MEM loads/stores and walks each
// request as sequential byte transactions, assembling read data little-endian.
//
// state      | meaning
// S_IDLE     | port free; samples requests, MEM ahead of IF
// S_IF_XFER  | IF fetch in progress (reads only, cancellable by flush)
// S_MEM_XFER | MEM load/store in progress, non-preemptive
// S_DONE     | one-cycle ready pulse to the owner, then back to idle
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int FETCH_BYTES = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_if_flush,
   output logic              o_if_ready,
   output logic [31:0]       o_if_data,
   input  logic [1:0]        i_mem_req,
   input  logic [1:0]        i_mem_size,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [31:0]       i_mem_wdata,
   output logic              o_mem_ready,
   output logic [31:0]       o_mem_rdata,
   output logic [ADDR_W-1:0] o_ram_a,
   output logic [7:0]        o_ram_dout,
   output logic              o_ram_wr,
   input  logic [7:0]        i_ram_din,
   output logic [1:0]        o_grant
);

   typedef enum logic [1:0] {S_IDLE, S_IF_XFER, S_MEM_XFER, S_DONE} state_t;

   localparam logic [2:0] LP_FETCH_N = 3'(FETCH_BYTES);

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [2:0]        r_nbytes;
   logic [2:0]        r_cnt;
   logic              r_store;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;

   logic              r_if_ready;
   logic [31:0]       r_if_data;
   logic              r_mem_ready;
   logic [31:0]       r_mem_rdata;
   logic [ADDR_W-1:0] r_ram_a;
   logic [7:0]        r_ram_dout;
   logic              r_ram_wr;
   logic [1:0]        r_grant;

   logic              w_mem_go;
   logic              w_if_go;
   logic              w_mem_store;
   logic [2:0]        w_mem_n;
   logic              w_last_issue;
   logic [1:0]        w_cap_idx;
   logic [31:0]       w_rdata_next;
   logic [ADDR_W-1:0] w_next_a;

   assign w_mem_go     = (i_mem_req == 2'b01) || (i_mem_req == 2'b10);
   assign w_mem_store  = (i_mem_req == 2'b10);
   assign w_if_go      = i_if_req && !i_if_flush;
   assign w_last_issue = (r_cnt == r_nbytes - 3'd1);
   assign w_cap_idx    = 2'(r_cnt - 3'd1);
   assign w_next_a     = r_base + ADDR_W'(r_cnt + 3'd1);

   always_comb begin
      w_mem_n = 3'd4;
      case (i_mem_size)
         2'b00:   w_mem_n = 3'd1;
         2'b01:   w_mem_n = 3'd2;
         default: w_mem_n = 3'd4;
      endcase
   end

   // RAM data lags its address by one cycle, so the byte arriving now belongs to r_cnt-1.
   always_comb begin
      w_rdata_next = r_rdata;
      w_rdata_next[{w_cap_idx, 3'b000} +: 8] = i_ram_din;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_nbytes    <= '0;
         r_cnt       <= '0;
         r_store     <= 1'b0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_if_ready  <= 1'b0;
         r_if_data   <= '0;
         r_mem_ready <= 1'b0;
         r_mem_rdata <= '0;
         r_ram_a     <= '0;
         r_ram_dout  <= '0;
         r_ram_wr    <= 1'b0;
         r_grant     <= 2'b00;
      end else begin
         r_if_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ram_a    <= '0;
               r_ram_dout <= '0;
               r_ram_wr   <= 1'b0;
               r_grant    <= 2'b00;
               r_cnt      <= '0;
               r_rdata    <= '0;
               if (w_mem_go) begin
                  r_state    <= S_MEM_XFER;
                  r_store    <= w_mem_store;
                  r_nbytes   <= w_mem_n;
                  r_base     <= i_mem_addr;
                  r_wdata    <= i_mem_wdata;
                  r_ram_a    <= i_mem_addr;
                  r_ram_wr   <= w_mem_store;
                  r_ram_dout <= w_mem_store ? i_mem_wdata[7:0] : 8'h00;
                  r_grant    <= 2'b10;
               end else if (w_if_go) begin
                  r_state  <= S_IF_XFER;
                  r_store  <= 1'b0;
                  r_nbytes <= LP_FETCH_N;
                  r_base   <= i_if_addr;
                  r_wdata  <= '0;
                  r_ram_a  <= i_if_addr;
                  r_grant  <= 2'b01;
               end
            end
            S_IF_XFER, S_MEM_XFER: begin
               if (r_state == S_IF_XFER && i_if_flush) begin
                  r_state    <= S_IDLE;
                  r_ram_a    <= '0;
                  r_ram_dout <= '0;
                  r_ram_wr   <= 1'b0;
                  r_grant    <= 2'b00;
               end else begin
                  if (!r_store && r_cnt != 3'd0) r_rdata <= w_rdata_next;
                  if (r_cnt == r_nbytes) begin
                     r_state <= S_DONE;
                     r_ram_a <= '0;
                     r_grant <= 2'b00;
                     if (r_state == S_IF_XFER) begin
                        r_if_ready <= 1'b1;
                        r_if_data  <= w_rdata_next;
                     end else begin
                        r_mem_ready <= 1'b1;
                        r_mem_rdata <= w_rdata_next;
                     end
                  end else if (w_last_issue) begin
                     if (r_store) begin
                        r_state     <= S_DONE;
                        r_mem_ready <= 1'b1;
                        r_ram_a     <= '0;
                        r_ram_dout  <= '0;
                        r_ram_wr    <= 1'b0;
                        r_grant     <= 2'b00;
                     end else begin
                        // extra capture cycle: address holds on the last byte
                        r_cnt    <= r_nbytes;
                        r_ram_wr <= 1'b0;
                     end
                  end else begin
                     r_cnt      <= r_cnt + 3'd1;
                     r_ram_a    <= w_next_a;
                     r_wdata    <= {8'h00, r_wdata[31:8]};
                     r_ram_dout <= r_store ? r_wdata[15:8] : 8'h00;
                     r_ram_wr   <= r_store;
                  end
               end
            end
            S_DONE: begin
               r_state    <= S_IDLE;
               r_ram_a    <= '0;
               r_ram_dout <= '0;
               r_ram_wr   <= 1'b0;
               r_grant    <= 2'b00;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_if_ready  = r_if_ready;
   assign o_if_data   = r_if_data;
   assign o_mem_ready = r_mem_ready;
   assign o_mem_rdata = r_mem_rdata;
   assign o_ram_a     = r_ram_a;
   assign o_ram_dout  = r_ram_dout;
   assign o_ram_wr    = r_ram_wr;
   assign o_grant     = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model plus a transaction-level reference model
// (expected bytes, addresses and latency derived from request size and direction).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush, if_ready;
   logic [31:0] if_addr, if_data;
   logic [1:0]  mem_req, mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout, ram_din;
   logic        ram_wr;
   logic [1:0]  grant;

   logic        poke_en = 1'b0;
   logic [9:0]  poke_a = '0;
   logic [7:0]  poke_d = '0;

   logic [7:0]  ram_arr   [0:1023];
   bit          ram_vld   [0:1023];
   logic [7:0]  model_mem [0:1023];

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_if   = '0;
   logic [31:0] exp_mem  = '0;
   bit          mem_known = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .FETCH_BYTES(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
      .o_if_ready(if_ready), .o_if_data(if_data),
      .i_mem_req(mem_req), .i_mem_size(mem_size), .i_mem_addr(mem_addr),
      .i_mem_wdata(mem_wdata), .o_mem_ready(mem_ready), .o_mem_rdata(mem_rdata),
      .o_ram_a(ram_a), .o_ram_dout(ram_dout), .o_ram_wr(ram_wr),
      .i_ram_din(ram_din), .o_grant(grant)
   );

   function automatic logic [7:0] init_byte(input logic [9:0] a);
      return 8'((a * 10'd37) >> 1) ^ 8'hA6;
   endfunction

   // 1 KiB RAM mirrored across the 32-bit space; untouched bytes read a fixed pattern.
   always @(posedge clk) begin
      if (poke_en) begin
         ram_arr[poke_a] <= poke_d;
         ram_vld[poke_a] <= 1'b1;
      end else if (ram_wr) begin
         ram_arr[ram_a[9:0]] <= ram_dout;
         ram_vld[ram_a[9:0]] <= 1'b1;
      end
      ram_din <= ram_vld[ram_a[9:0]] ? ram_arr[ram_a[9:0]] : init_byte(ram_a[9:0]);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      poke_en = 1'b1;
      poke_a  = a[9:0];
      poke_d  = d;
      model_mem[a[9:0]] = d;
      step();
      poke_en = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_if_ready"}, 32'(if_ready), 0);
      chk({tag, "_if_data"}, if_data, 0);
      chk({tag, "_mem_ready"}, 32'(mem_ready), 0);
      chk({tag, "_mem_rdata"}, mem_rdata, 0);
      chk({tag, "_ram_a"}, ram_a, 0);
      chk({tag, "_ram_dout"}, 32'(ram_dout), 0);
      chk({tag, "_ram_wr"}, 32'(ram_wr), 0);
      chk({tag, "_grant"}, 32'(grant), 0);
   endtask

   // kind: 0 fetch, 1 load, 2 store. Called from an idle cycle; returns in the idle cycle after DONE.
   task automatic run_txn(input int kind, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit bg_if, input logic [31:0] bg_addr,
                          input logic [1:0] junk);
      int          n, lat, c;
      bit          seen, store;
      logic [31:0] exp, wsh;
      logic [1:0]  gexp;
      store = (kind == 2);
      n     = (kind == 0) ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      lat   = store ? n + 1 : n + 2;
      gexp  = (kind == 0) ? 2'b01 : 2'b10;
      exp   = '0;
      for (int i = 0; i < n; i++) begin
         logic [31:0] ba;
         ba  = addr + 32'(i);
         exp = exp | (32'(model_mem[ba[9:0]]) << (8 * i));
      end
      if (kind == 0) begin
         if_req  = 1'b1;
         if_addr = addr;
         mem_req = junk;
      end else begin
         mem_req   = store ? 2'b10 : 2'b01;
         mem_size  = size;
         mem_addr  = addr;
         mem_wdata = wdata;
         if (bg_if) begin
            if_req  = 1'b1;
            if_addr = bg_addr;
         end
      end
      seen = 1'b0;
      c    = 0;
      while (!seen && c < 20) begin
         step();
         c++;
         if (((kind == 0) ? if_ready : mem_ready) === 1'b1) begin
            seen = 1'b1;
         end else begin
            chk("grant", 32'(grant), 32'(gexp));
            chk("other_ready", 32'((kind == 0) ? mem_ready : if_ready), 0);
            if (c <= n) begin
               chk("ram_a", ram_a, addr + 32'(c - 1));
               chk("ram_wr", 32'(ram_wr), 32'(store));
               if (store) begin
                  wsh = wdata >> (8 * (c - 1));
                  chk("ram_dout", 32'(ram_dout), 32'(wsh[7:0]));
               end
            end else if (c == n + 1 && !store) begin
               chk("ram_a_hold", ram_a, addr + 32'(n - 1));
               chk("ram_wr_cap", 32'(ram_wr), 0);
            end
         end
      end
      chk("latency", 32'(c), 32'(lat));
      if (seen) begin
         if (kind == 0) exp_if = exp;
         else if (!store) begin
            exp_mem   = exp;
            mem_known = 1'b1;
         end else begin
            for (int i = 0; i < n; i++) begin
               logic [31:0] ba;
               ba  = addr + 32'(i);
               wsh = wdata >> (8 * i);
               model_mem[ba[9:0]] = wsh[7:0];
            end
            mem_known = 1'b0;
         end
      end
      chk("if_data", if_data, exp_if);
      if (mem_known) chk("mem_rdata", mem_rdata, exp_mem);
      if (kind == 0 || !bg_if) if_req = 1'b0;
      mem_req = 2'b00;
      step();
      chk("idle_if_ready", 32'(if_ready), 0);
      chk("idle_mem_ready", 32'(mem_ready), 0);
      chk("idle_grant", 32'(grant), 0);
      chk("idle_ram_wr", 32'(ram_wr), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          kind;
      logic [1:0]  sz, junk;
      logic [31:0] a, wd;
      bit          bg;

      for (int i = 0; i < 1024; i++) model_mem[i] = init_byte(10'(i));
      rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      mem_req = 2'b00; mem_size = 2'b00; mem_addr = '0; mem_wdata = '0;
      step();
      step();
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      step();

      poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
      poke(32'h8, 8'h80);
      poke(32'hFFFF_FFFF, 8'hA5); poke(32'h0, 8'h5A);

      run_txn(0, 2'b00, 32'h100, '0, 1'b0, '0, 2'b00);
      chk("fetch_word", if_data, 32'h4433_2211);

      run_txn(2, 2'b10, 32'h20, 32'hDEAD_BEEF, 1'b0, '0, 2'b00);
      run_txn(1, 2'b10, 32'h20, '0, 1'b0, '0, 2'b00);
      chk("store_readback", mem_rdata, 32'hDEAD_BEEF);

      run_txn(1, 2'b00, 32'h8, '0, 1'b1, 32'h100, 2'b00);
      chk("simul_byte", mem_rdata, 32'h0000_0080);
      run_txn(0, 2'b00, 32'h100, '0, 1'b0, '0, 2'b00);

      // flush on the second cycle of a fetch
      if_req = 1'b1; if_addr = 32'h300;
      step();
      step();
      if_flush = 1'b1;
      step();
      chk("flush_grant", 32'(grant), 0);
      chk("flush_ready", 32'(if_ready), 0);
      if_req = 1'b0; if_flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("flush_no_ready", 32'(if_ready), 0);
      end
      chk("flush_data_kept", if_data, 32'h4433_2211);
      run_txn(0, 2'b00, 32'h200, '0, 1'b0, '0, 2'b00);

      // flush in idle blocks IF but not MEM
      if_req = 1'b1; if_addr = 32'h204; if_flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_flush_grant", 32'(grant), 0);
      end
      run_txn(1, 2'b01, 32'h30, '0, 1'b1, 32'h204, 2'b00);
      step();
      chk("idle_flush_after_mem", 32'(grant), 0);
      if_req = 1'b0; if_flush = 1'b0;
      step();

      mem_req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("req11_grant", 32'(grant), 0);
      end
      mem_req = 2'b00;
      step();

      run_txn(1, 2'b01, 32'hFFFF_FFFF, '0, 1'b0, '0, 2'b00);
      chk("wrap_half", mem_rdata, 32'h0000_5AA5);

      // reset in the middle of a word store
      mem_req = 2'b10; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'hCAFE_F00D;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      model_mem[10'h40] = 8'h0D;
      exp_if = '0; exp_mem = '0; mem_known = 1'b1;
      mem_req = 2'b00;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("postrst_mem_ready", 32'(mem_ready), 0);
         chk("postrst_grant", 32'(grant), 0);
      end
      run_txn(1, 2'b10, 32'h40, '0, 1'b0, '0, 2'b00);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 2);
         sz   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else a = 32'($urandom_range(0, 1023));
         wd   = $urandom;
         junk = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
         bg   = (kind != 0) && ($urandom_range(0, 1) == 1);
         run_txn(kind, sz, a, wd, bg, 32'($urandom_range(0, 1023)), junk);
         if (bg) run_txn(0, 2'b00, if_addr, '0, 1'b0, '0, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the single byte-wide synchronous RAM port.
- Arbitrates between instruction fetch (IF, always 4-byte reads) and the MEM stage (1/2/4-byte loads and stores).
- Splits each granted word-level request into sequential byte transactions, assembles read bytes little-endian, and returns a one-cycle ready pulse with data.
- MEM issues one request per access; it no longer sequences byte addresses itself.

Parameters:
ADDR_W, 32, width of request and RAM addresses
FETCH_BYTES, 4, bytes per IF fetch (fixed usage 4; allowed range 1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  IF fetch request; held until if_ready
if_addr  in  ADDR_W  fetch base address
if_flush  in  1  cancel an in-flight IF fetch (branch redirect)
if_ready  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched word, little-endian
mem_req  in  2  00 none, 01 load, 10 store, 11 treated as none; held until mem_ready
mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_addr  in  ADDR_W  access base address
mem_wdata  in  32  store data; byte i = bits [8i+7:8i]
mem_ready  out  1  one-cycle pulse: access complete
mem_rdata  out  32  load data, zero-extended above size (MEM performs sign extension)
ram_a  out  ADDR_W  RAM byte address
ram_dout  out  8  RAM write byte
ram_wr  out  1  1 = write this cycle
ram_din  in  8  RAM read byte, valid the cycle after its address
grant  out  2  00 idle, 01 IF owns port, 10 MEM owns port

Behaviour:
Reset (rst low, any time, including mid-burst):
- State goes to IDLE immediately.
- All outputs go to 0; data registers and byte counter are cleared.
- An in-flight burst is lost. No ready pulse is generated.

States:
- IDLE: ram_a = 0, ram_wr = 0, grant = 00. At a clock edge:
  - If mem_req is 01 or 10, go to MEM_XFER. MEM has priority over IF.
  - Else if if_req is high and if_flush is low, go to IF_XFER.
  - On entry, latch base address, N (1/2/4, or FETCH_BYTES for IF), direction and wdata; set byte counter = 0.
- IF_XFER / MEM_XFER: non-preemptive.
  - Issue cycle i (0..N-1): ram_a = base+i, computed modulo 2^ADDR_W (address wrap is allowed).
  - Store: ram_dout = wdata byte i and ram_wr = 1 in issue cycles only.
  - Load: ram_din is captured into byte i at the end of issue cycle i+1. One extra capture cycle follows the last issue; during it ram_wr = 0 and ram_a holds base+N-1.
  - grant = 01 or 10 for the whole transfer.
- DONE: one cycle.
  - The matching ready is high. if_data or mem_rdata is updated in the same cycle and held until the next completion of that requester.
  - No request is sampled in DONE; the next state is always IDLE. The requester must drop its req during its ready cycle.

Latency from the sampling edge E0, with the ready cycle numbered from 1 after E0:
- Read of N bytes: ready in cycle N+2. Word fetch: cycle 6; byte load: cycle 3.
- Write of N bytes: ready in cycle N+1. Word store: cycle 5; byte store: cycle 2.

if_flush:
- In IF_XFER: the next state is IDLE, no if_ready pulse, and if_data is unchanged.
- In IDLE: blocks the IF grant at that edge; MEM can still be granted.
- In MEM_XFER or DONE: ignored.

Other rules:
- Requests changing mid-transfer are ignored; the latched values are used.
- No write is ever issued during an IF transfer.
- A back-to-back MEM request after DONE is granted ahead of a waiting IF request, so IF can be starved. This is accepted; MEM traffic is bounded by the pipeline stall.

Test Plan:
- Word fetch: mem_req = 00, if_req = 1, if_addr = 0x100, RAM[0x100..0x103] = 11 22 33 44 → ram_a steps 0x100..0x103 in cycles 1..4; if_ready in cycle 6; if_data = 0x44332211; grant = 01 in cycles 1..5.
- Word store: mem_req = 10, size = 10, mem_addr = 0x20, mem_wdata = 0xDEADBEEF → ram_wr = 1 in cycles 1..4 with bytes EF BE AD DE at 0x20..0x23; mem_ready in cycle 5.
- Simultaneous requests: if_req = 1 and mem_req = 01 (size 00, addr 0x8, RAM = 0x80) → MEM granted first, mem_rdata = 0x00000080 in cycle 3; IF granted after DONE and IDLE, if_ready 6 cycles after its grant edge.
- Flush mid-fetch: if_flush pulsed in cycle 2 of a fetch → no if_ready, if_data unchanged, grant = 00 the next cycle; a new fetch at 0x200 completes normally.
- Half load with address wrap: mem_addr = 0xFFFFFFFF, size = 01 → ram_a = 0xFFFFFFFF then 0x00000000; mem_ready in cycle 4 with bits [31:16] = 0.
- Reset mid-store: rst low during cycle 2 of a word store → all outputs 0 asynchronously; after release, state is IDLE and no mem_ready pulse occurs.
